// File: rtl/image_loader_if.sv
// Valid/ready pixel stream carrying one BEAT_WIDTH-pixel beat per transfer.
// The master is the image source; the slave is the loader.
interface image_loader_if #(
  parameter int BEAT_WIDTH = 4
);
  logic [BEAT_WIDTH-1:0] pixel_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  modport master (output pixel_data, output in_valid, output in_last, input in_ready);
  modport slave  (input pixel_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/image_loader.sv
// Ping-pong image loader: assembles streamed beats into two banks and holds a
// completed bank stable for the CNN while the next image streams into the other.
module image_loader #(
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int BEAT_WIDTH   = 4,
  parameter int CNN_CYCLES   = 632
) (
  input  logic                                    clk,
  input  logic                                    rst,
  image_loader_if.slave                           s,
  output logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] image_output,
  output logic                                    convolution_enable,
  output logic                                    busy,
  output logic                                    frame_error
);

  localparam int BEATS = IMAGE_WIDTH / BEAT_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int NW    = $clog2(CNN_CYCLES + 1);

  localparam logic [CW-1:0] C_LAST = CW'(BEATS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [NW-1:0] N_LOAD = NW'(CNN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, HOLD} state_t;

  logic [1:0][IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] bank_q;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          frame_error_q, frame_error_d;
  state_t        state_q;
  logic [NW-1:0] cnt_q;
  logic          conv_en_q;
  logic          busy_q;

  logic accept;
  logic final_beat;
  logic set_full;
  logic release_bank;

  assign s.in_ready    = !full_q[wr_bank_q];
  assign accept        = s.in_valid && s.in_ready;
  assign final_beat    = (r_q == R_LAST) && (c_q == C_LAST);
  assign release_bank  = (state_q == HOLD) && (cnt_q == '0);

  // Any mismatch between in_last and the final position drops the partial image.
  always_comb begin
    r_d           = r_q;
    c_d           = c_q;
    wr_bank_d     = wr_bank_q;
    set_full      = 1'b0;
    frame_error_d = 1'b0;
    if (accept) begin
      if (final_beat && s.in_last) begin
        set_full  = 1'b1;
        wr_bank_d = ~wr_bank_q;
        r_d       = '0;
        c_d       = '0;
      end else if (final_beat || s.in_last) begin
        frame_error_d = 1'b1;
        r_d           = '0;
        c_d           = '0;
      end else if (c_q == C_LAST) begin
        c_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // The write and release sides never target the same bank in one cycle.
  always_comb begin
    full_d = full_q;
    if (set_full) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q        <= '0;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      r_q           <= '0;
      c_q           <= '0;
      frame_error_q <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      conv_en_q     <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      if (accept) begin
        bank_q[wr_bank_q][r_q][c_q*BEAT_WIDTH +: BEAT_WIDTH] <= s.pixel_data;
      end
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      r_q           <= r_d;
      c_q           <= c_d;
      frame_error_q <= frame_error_d;

      // Outputs are assigned on the transition so they line up with the state.
      unique case (state_q)
        IDLE: begin
          conv_en_q <= 1'b1;
          busy_q    <= 1'b0;
          if (full_q[rd_bank_q]) begin
            state_q   <= START;
            conv_en_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          state_q   <= HOLD;
          cnt_q     <= N_LOAD;
          conv_en_q <= 1'b1;
          busy_q    <= 1'b1;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            rd_bank_q <= ~rd_bank_q;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          conv_en_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign image_output       = bank_q[rd_bank_q];
  assign convolution_enable = conv_en_q;
  assign busy               = busy_q;
  assign frame_error        = frame_error_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader: one task per scenario, each
// comparing DUT outputs against values computed from a small pixel model.
module tb_image_loader;

  localparam int W     = 28;
  localparam int H     = 28;
  localparam int BW    = 4;
  localparam int N     = 632;
  localparam int BEATS = W / BW;
  localparam int NB    = H * BEATS;

  logic clk = 1'b0;
  logic rst;
  logic [H-1:0][W-1:0] imageOutput;
  logic convEn;
  logic busy;
  logic frameError;

  always #5 clk = ~clk;

  image_loader_if #(.BEAT_WIDTH(BW)) sIf ();

  image_loader #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .BEAT_WIDTH  (BW),
    .CNN_CYCLES  (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s                 (sIf),
    .image_output      (imageOutput),
    .convolution_enable(convEn),
    .busy              (busy),
    .frame_error       (frameError)
  );

  int cycle = 0;
  int startCount = 0;
  int lastStart = 0;
  int ferrCount = 0;
  int busyCount = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (convEn === 1'b0) begin
        startCount++;
        lastStart = cycle;
      end
      if (frameError === 1'b1) ferrCount++;
      if (busy === 1'b1) busyCount++;
    end
  end

  function automatic logic pix(input int t, input int r, input int c);
    case (t)
      0:       return ((r + c) % 2) == 1;
      1:       return 1'b1;
      2:       return ((r * 3 + c * 5) % 7) == 0;
      3:       return (((r ^ c) >> 1) & 1) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int countErrs(input int t);
    int e = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (imageOutput[r][c] !== pix(t, r, c)) e++;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [BW-1:0] d, input logic last, output int stamp);
    int waited = 0;
    bit done = 0;
    logic rdy;
    stamp = -1;
    sIf.pixel_data = d;
    sIf.in_valid   = 1'b1;
    sIf.in_last    = last;
    while (!done) begin
      @(negedge clk);
      rdy = sIf.in_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        stamp = cycle;
        done  = 1;
      end else if (++waited > 3 * N) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL beat_accept_timeout: waited %0d cycles, required accept", waited);
        done = 1;
      end
    end
    sIf.in_valid = 1'b0;
    sIf.in_last  = 1'b0;
  endtask

  task automatic streamImage(input int t, input int nBeats, input int lastIdx, input int gapPct,
                             output int firstStamp, output int finalStamp);
    logic [BW-1:0] d;
    int st;
    firstStamp = -1;
    finalStamp = -1;
    for (int k = 0; k < nBeats; k++) begin
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct) tick();
      for (int b = 0; b < BW; b++) d[b] = pix(t, k / BEATS, (k % BEATS) * BW + b);
      sendBeat(d, k == lastIdx, st);
      if (st < 0) break;
      if (k == 0) firstStamp = st;
      finalStamp = st;
    end
  endtask

  task automatic waitStarts(input int target, input string name);
    int n = 0;
    while (startCount < target && n < 2 * N + 400) begin
      tick();
      n++;
    end
    if (startCount < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_start_timeout: got %0d starts, want %0d", name, startCount, target);
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 2 * N + 400) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_idle_timeout: busy=%b, want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sIf.in_valid   = 1'b0;
    sIf.in_last    = 1'b0;
    sIf.pixel_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    vectors++; if (convEn !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_conv_en: got %b, want 1", convEn); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    vectors++; if (frameError !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_error: got %b, want 0", frameError); end
    vectors++; if (sIf.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, want 1", sIf.in_ready); end
    vectors++; if (countErrs(4) !== 0) begin miscompares++; $display("[TB] FAIL reset_image: got %0d bad pixels, want 0", countErrs(4)); end
  endtask

  task automatic test_single_image();
    int s0 = startCount, b0 = busyCount, f, l;
    streamImage(0, NB, NB - 1, 0, f, l);
    vectors++; if (convEn !== 1'b1) begin miscompares++; $display("[TB] FAIL single_conv_en_e0: got %b, want 1", convEn); end
    tick();
    vectors++; if (convEn !== 1'b0) begin miscompares++; $display("[TB] FAIL single_conv_en_e1: got %b, want 0", convEn); end
    tick();
    vectors++; if (convEn !== 1'b1) begin miscompares++; $display("[TB] FAIL single_conv_en_e2: got %b, want 1", convEn); end
    vectors++; if (lastStart !== l + 1) begin miscompares++; $display("[TB] FAIL single_start_cycle: got %0d, want %0d", lastStart, l + 1); end
    vectors++; if (countErrs(0) !== 0) begin miscompares++; $display("[TB] FAIL single_image: got %0d bad pixels, want 0", countErrs(0)); end
    waitIdle("single");
    vectors++; if (busyCount - b0 !== N + 1) begin miscompares++; $display("[TB] FAIL single_busy_len: got %0d, want %0d", busyCount - b0, N + 1); end
    vectors++; if (startCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL single_start_count: got %0d, want 1", startCount - s0); end
  endtask

  task automatic test_back_to_back();
    int s0 = startCount, fa0, fa, fb0, fb;
    streamImage(0, NB, NB - 1, 0, fa0, fa);
    streamImage(1, NB, NB - 1, 0, fb0, fb);
    vectors++; if (fb !== fa + NB) begin miscompares++; $display("[TB] FAIL b2b_b_accept: got %0d, want %0d", fb, fa + NB); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy_during_b: got %b, want 1", busy); end
    vectors++; if (startCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL b2b_starts_mid: got %0d, want 1", startCount - s0); end
    waitStarts(s0 + 2, "b2b");
    vectors++; if (lastStart !== fa + 1 + N + 2) begin miscompares++; $display("[TB] FAIL b2b_start_gap: got %0d, want %0d", lastStart, fa + 1 + N + 2); end
    vectors++; if (countErrs(1) !== 0) begin miscompares++; $display("[TB] FAIL b2b_image_b: got %0d bad pixels, want 0", countErrs(1)); end
    waitIdle("b2b");
  endtask

  task automatic test_backpressure();
    int s0 = startCount, x, fa, fb, c0, fc;
    streamImage(0, NB, NB - 1, 0, x, fa);
    streamImage(1, NB, NB - 1, 0, x, fb);
    vectors++; if (sIf.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready_full: got %b, want 0", sIf.in_ready); end
    streamImage(3, NB, NB - 1, 0, c0, fc);
    vectors++; if (c0 !== fa + N + 3) begin miscompares++; $display("[TB] FAIL bp_c_first_accept: got %0d, want %0d", c0, fa + N + 3); end
    waitStarts(s0 + 3, "bp");
    vectors++; if (lastStart !== fa + 2 * N + 5) begin miscompares++; $display("[TB] FAIL bp_c_start: got %0d, want %0d", lastStart, fa + 2 * N + 5); end
    vectors++; if (countErrs(3) !== 0) begin miscompares++; $display("[TB] FAIL bp_image_c: got %0d bad pixels, want 0", countErrs(3)); end
    waitIdle("bp");
  endtask

  task automatic test_framing_errors();
    int s0, e0, x, f;
    for (int pass = 0; pass < 2; pass++) begin
      s0 = startCount;
      e0 = ferrCount;
      if (pass == 0) streamImage(2, 50, 49, 0, x, f);
      else           streamImage(2, NB, -1, 0, x, f);
      repeat (5) tick();
      vectors++; if (ferrCount - e0 !== 1) begin miscompares++; $display("[TB] FAIL frame_err_pulse%0d: got %0d, want 1", pass, ferrCount - e0); end
      vectors++; if (startCount !== s0) begin miscompares++; $display("[TB] FAIL frame_no_start%0d: got %0d, want %0d", pass, startCount, s0); end
      streamImage(3 - pass, NB, NB - 1, 0, x, f);
      waitStarts(s0 + 1, "frame");
      vectors++; if (lastStart !== f + 1) begin miscompares++; $display("[TB] FAIL frame_clean_start%0d: got %0d, want %0d", pass, lastStart, f + 1); end
      vectors++; if (countErrs(3 - pass) !== 0) begin miscompares++; $display("[TB] FAIL frame_clean_image%0d: got %0d bad pixels, want 0", pass, countErrs(3 - pass)); end
      waitIdle("frame");
    end
  endtask

  task automatic test_reset_mid_hold();
    int s0 = startCount, x, f;
    streamImage(1, NB, NB - 1, 0, x, f);
    waitStarts(s0 + 1, "rsthold");
    streamImage(2, 30, -1, 0, x, f);
    repeat (69) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rsthold_busy: got %b, want 0", busy); end
    vectors++; if (convEn !== 1'b1) begin miscompares++; $display("[TB] FAIL rsthold_conv_en: got %b, want 1", convEn); end
    vectors++; if (countErrs(4) !== 0) begin miscompares++; $display("[TB] FAIL rsthold_image: got %0d bad pixels, want 0", countErrs(4)); end
    vectors++; if (sIf.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rsthold_in_ready: got %b, want 1", sIf.in_ready); end
    repeat (10) tick();
    vectors++; if (startCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL rsthold_no_restart: got %0d, want 1", startCount - s0); end
  endtask

  task automatic test_random_gaps();
    int s0 = startCount, x, f;
    streamImage(3, NB, NB - 1, 30, x, f);
    waitStarts(s0 + 1, "gaps");
    vectors++; if (lastStart !== f + 1) begin miscompares++; $display("[TB] FAIL gaps_start: got %0d, want %0d", lastStart, f + 1); end
    vectors++; if (countErrs(3) !== 0) begin miscompares++; $display("[TB] FAIL gaps_image: got %0d bad pixels, want 0", countErrs(3)); end
    waitIdle("gaps");
    repeat (5) tick();
    vectors++; if (startCount - s0 !== 1) begin miscompares++; $display("[TB] FAIL gaps_start_count: got %0d, want 1", startCount - s0); end
  endtask

  initial begin
    rst = 1'b1;
    sIf.in_valid   = 1'b0;
    sIf.in_last    = 1'b0;
    sIf.pixel_data = '0;
    $display("[TB] image_loader bench starting");
    test_reset();
    test_single_image();
    test_back_to_back();
    test_backpressure();
    test_framing_errors();
    test_reset_mid_hold();
    test_random_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Upstream input stage for `CNN`. Accepts a binary image as a valid/ready stream of `BEAT_WIDTH`-pixel beats and assembles it into one of two ping-pong image banks. It presents a completed bank on `image_output` and issues the one-cycle active-low `convolution_enable` start pulse. It then holds the bank stable for the fixed CNN run length, so the next image can stream in while the current one is being convolved.

## Interface

**Parameters**
- `IMAGE_WIDTH`, 28: pixels per row.
- `IMAGE_HEIGHT`, 28: rows per image.
- `BEAT_WIDTH`, 4: pixels per stream beat. `IMAGE_WIDTH % BEAT_WIDTH == 0` is required.
- `CNN_CYCLES`, 632: cycles the bank is held after the start pulse. This covers 625 convolution cycles plus the pooling, flatten, fully-connected and output stages, plus margin.

**Ports**
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pixel_data`, in, `BEAT_WIDTH`: pixels of one beat. Bit 0 is the leftmost pixel.
- `in_valid`, in, 1: the beat on `pixel_data` is valid.
- `in_last`, in, 1: marks the final beat of an image. Only meaningful when `in_valid` is high.
- `in_ready`, out, 1: the loader can accept a beat.
- `image_output`, out, `[IMAGE_HEIGHT][IMAGE_WIDTH]` x 1: image presented to `CNN.image_input`.
- `convolution_enable`, out, 1: active-low start pulse to `CNN`.
- `busy`, out, 1: a bank is currently held for the CNN.
- `frame_error`, out, 1: one-cycle pulse on a framing error.

## Operation

**Storage and pointers**
- Two banks, each `IMAGE_HEIGHT x IMAGE_WIDTH` bits.
- `full[1:0]` flags, a write pointer `wr_bank` and a read pointer `rd_bank`.

**Write side**
- A beat is accepted when `in_valid && in_ready`.
- `in_ready = !full[wr_bank]`.
- Row counter `r` and column-beat counter `c`, with `c` in `0..IMAGE_WIDTH/BEAT_WIDTH-1`.
- Each accepted beat writes `bank[wr_bank][r][c*BEAT_WIDTH + b] = pixel_data[b]`, then advances `c`, wrapping into `r`.
- **Final beat** (`r == IMAGE_HEIGHT-1`, last `c`) with `in_last=1`:
  - set `full[wr_bank]`;
  - toggle `wr_bank`;
  - clear `r` and `c`.
- **Framing error**, either of:
  - `in_last=1` on a non-final beat, or
  - `in_last=0` on the final beat.
- On a framing error:
  - pulse `frame_error` for one cycle;
  - discard the partial image by clearing `r` and `c`;
  - leave `full` and `wr_bank` unchanged.
- The erroring beat is consumed.

**Read-side FSM**
- **IDLE:** if `full[rd_bank]`, go to START.
- **START:** `convolution_enable=0` for exactly this one cycle; go to HOLD; load `cnt = CNN_CYCLES-1`.
- **HOLD:** `busy=1`; decrement `cnt`. At `cnt==0`, on the next edge:
  - clear `full[rd_bank]`;
  - toggle `rd_bank`;
  - go to IDLE.
- **Output:** `image_output = bank[rd_bank]` combinationally. It is stable throughout START and HOLD because a full bank is never written.
- **Registered outputs:** `convolution_enable` and `busy` are registered. `busy=1` in START and HOLD.

## Timing

**Reset values**
- Banks all 0, so `image_output` is all 0.
- `full=0`, `wr_bank=rd_bank=0`, `r=c=0`, FSM in IDLE.
- `convolution_enable=1`, `busy=0`, `frame_error=0`.
- `in_ready=1` in the first cycle after reset deasserts.

**Reset mid-operation**
- Resets the state above immediately, including mid-image and mid-HOLD.
- Partial and held images are lost.
- `convolution_enable` returns high on the reset edge.

**Latency**
- Edge E0 accepts the final beat.
- `convolution_enable` is low from E1 to E2.
- The bank is released at edge E2+`CNN_CYCLES`.

**Throughput and backpressure**
- Streaming continues into the other bank during HOLD.
- `in_ready` drops only when both banks are full.
- `in_ready` rises on the cycle after the release edge.

**Simultaneous events**
- Final-beat set of `full[wr_bank]` and release clear of `full[rd_bank]` in the same cycle: both take effect, since they are different banks.
- Release and a new full bank in the same cycle: the FSM passes through IDLE for one cycle, then enters START.
- The minimum gap between start pulses is `CNN_CYCLES+2` cycles.

**Stalls**
- `in_valid=0` mid-image holds `r` and `c`. There is no timeout.

## Test plan

- **Single image:** reset, then stream 196 beats of a checkerboard, `in_last` on beat 196.
  - `convolution_enable` is low for exactly one cycle, 1 edge after the accept.
  - `image_output[r][c] == (r+c)&1`.
  - `busy` is high for `CNN_CYCLES+1` cycles.
- **Back-to-back:** stream image A, then immediately image B (all ones).
  - B is fully accepted during A's HOLD.
  - The second start pulse occurs exactly `CNN_CYCLES+2` cycles after the first.
  - `image_output` switches to all ones at the first release.
- **Backpressure:** stream A, B and C without gaps.
  - `in_ready` is 0 from B's final beat until A's release.
  - Beats offered while `in_ready` is 0 are not captured.
  - C is correct.
- **Framing errors:**
  - `in_last` on beat 50: `frame_error` pulses once; no start pulse; a subsequent clean image loads correctly.
  - Repeat with `in_last=0` on beat 196: same behaviour.
- **Reset mid-HOLD:** assert `rst` at HOLD cycle 100.
  - Next cycle: `busy=0`, `convolution_enable=1`, `image_output` all 0, `in_ready=1`.
- **Random `in_valid` gaps:** 30% idle cycles.
  - Image contents match the reference pixel order.
  - No spurious start pulses.
